// File: rtl/l1c_xmon.sv
// Single-reservation LR/SC exclusive monitor feeding the L1 exclusive-write path.
// Optional reservation lifetime bound enabled by defining L1C_XMON_TIMEOUT_EN.
module l1c_xmon #(
  parameter int ADDR_WIDTH = 32,
  parameter int GRAN_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [ADDR_WIDTH-1:0]          core_paddr,
  input  logic                           lr_vld,
  input  logic                           sc_vld,
  input  logic                           xmon_clr,
  input  logic                           snp_vld,
  input  logic [ADDR_WIDTH-1:0]          snp_addr,
  output logic                           xmon_xstate,
  output logic                           resv_vld,
  output logic [ADDR_WIDTH-GRAN_WIDTH-1:0] resv_addr
);

  localparam int TAG_W = ADDR_WIDTH - GRAN_WIDTH;

  function automatic logic [TAG_W-1:0] gran_tag(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:GRAN_WIDTH];
  endfunction

  logic                  resv_vld_q, resv_vld_d;
  logic [TAG_W-1:0]      resv_addr_q, resv_addr_d;
  logic                  snp_vld_q;
  logic [ADDR_WIDTH-1:0] snp_addr_q;
  logic                  snp_hit_s;
  logic                  lr_race_s;
  logic                  expire_s;
  logic                  xstate_s;
  logic                  unused_bits_s;

  // Offset bits inside a granule never take part in any compare.
  assign unused_bits_s = ^{core_paddr[GRAN_WIDTH-1:0], snp_addr_q[GRAN_WIDTH-1:0]};

  // Registered snoop stage: other masters' write handshakes, one cycle late.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snp_vld_q  <= 1'b0;
      snp_addr_q <= '0;
    end else begin
      snp_vld_q  <= snp_vld;
      snp_addr_q <= snp_addr;
    end
  end

`ifdef L1C_XMON_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reservation age: restarts on every LR, saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (lr_vld) begin
      cnt_d = '0;
    end else if (resv_vld_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Age counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_s = resv_vld_q && (cnt_q == TO_VAL);
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT;
  assign expire_s = 1'b0;
`endif

  // Conflict detection and prioritized reservation update.
  always_comb begin
    snp_hit_s   = snp_vld_q && resv_vld_q && (gran_tag(snp_addr_q) == resv_addr_q);
    // A write already in flight to the new LR granule predates the reservation.
    lr_race_s   = snp_vld_q && (gran_tag(snp_addr_q) == gran_tag(core_paddr));
    resv_vld_d  = resv_vld_q;
    resv_addr_d = resv_addr_q;
    if (xmon_clr || sc_vld || snp_hit_s || expire_s) begin
      resv_vld_d = 1'b0;
    end else if (lr_vld) begin
      if (lr_race_s) begin
        resv_vld_d = 1'b0;
      end else begin
        resv_vld_d  = 1'b1;
        resv_addr_d = gran_tag(core_paddr);
      end
    end else begin
      resv_vld_d = resv_vld_q;
    end
    xstate_s = resv_vld_q && (gran_tag(core_paddr) == resv_addr_q) && !snp_hit_s && !xmon_clr;
  end

  // Reservation register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resv_vld_q  <= 1'b0;
      resv_addr_q <= '0;
    end else begin
      resv_vld_q  <= resv_vld_d;
      resv_addr_q <= resv_addr_d;
    end
  end

  // xmon_xstate must react to a same-cycle clear or snoop hit, so it stays combinational.
  assign xmon_xstate = xstate_s;
  assign resv_vld    = resv_vld_q;
  assign resv_addr   = resv_addr_q;

endmodule

// File: tb/tb_l1c_xmon.sv
// Randomized and directed bench for l1c_xmon against a granule-level reservation model.
module tb_l1c_xmon;
  localparam int AW = 32;
  localparam int GW = 4;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] core_paddr = '0;
  logic          lr_vld = 1'b0, sc_vld = 1'b0, xmon_clr = 1'b0, snp_vld = 1'b0;
  logic [AW-1:0] snp_addr = '0;
  logic          xmon_xstate, resv_vld;
  logic [AW-GW-1:0] resv_addr;

  l1c_xmon #(.ADDR_WIDTH(AW), .GRAN_WIDTH(GW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .core_paddr(core_paddr), .lr_vld(lr_vld), .sc_vld(sc_vld),
    .xmon_clr(xmon_clr), .snp_vld(snp_vld), .snp_addr(snp_addr),
    .xmon_xstate(xmon_xstate), .resv_vld(resv_vld), .resv_addr(resv_addr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: one reservation, a remembered last-cycle snoop, and the cycle of the last LR.
  bit          m_vld;
  logic [27:0] m_tag;
  bit          m_psv;
  logic [31:0] m_psa;
  int          m_lr_cyc;

  logic        s_x, s_v;
  logic [27:0] s_a;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [27:0] gran(input logic [31:0] a);
    return a[31:4];
  endfunction

  task automatic model_reset();
    m_vld = 1'b0; m_tag = '0; m_psv = 1'b0; m_psa = '0; m_lr_cyc = -100000;
  endtask

  // Entered at posedge+1: drive, check at negedge, then advance the model across the edge.
  task automatic cycle(input bit lr, input bit sc, input bit clr, input bit snp,
                       input logic [31:0] pa, input logic [31:0] sa);
    bit hit, exp_x, expd, race;
    lr_vld = lr; sc_vld = sc; xmon_clr = clr; snp_vld = snp; core_paddr = pa; snp_addr = sa;
    #4;
    hit   = m_psv && m_vld && (gran(m_psa) == m_tag);
    exp_x = m_vld && (gran(pa) == m_tag) && !hit && !clr;
    s_x = xmon_xstate; s_v = resv_vld; s_a = resv_addr;
    chk_val("xstate", {31'd0, s_x}, {31'd0, exp_x});
    chk_val("resv_vld", {31'd0, s_v}, {31'd0, m_vld});
    chk_val("resv_addr", {4'd0, s_a}, {4'd0, m_tag});
    @(posedge clk);
`ifdef L1C_XMON_TIMEOUT_EN
    expd = m_vld && ((cyc - m_lr_cyc) == TO + 1);
`else
    expd = 1'b0;
`endif
    race = m_psv && (gran(m_psa) == gran(pa));
    if (clr || sc || hit || expd) begin
      m_vld = 1'b0;
    end else if (lr) begin
      m_vld = !race;
      if (!race) m_tag = gran(pa);
    end
    if (lr) m_lr_cyc = cyc;
    m_psv = snp; m_psa = sa;
    cyc++;
    #1;
  endtask

  task automatic idle(input logic [31:0] pa);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, pa, 32'd0);
  endtask

  initial begin
    logic [31:0] pa, sa;
    model_reset();
    #12;
    chk_val("rst_resv_vld", {31'd0, resv_vld}, 32'd0);
    chk_val("rst_resv_addr", {4'd0, resv_addr}, 32'd0);
    chk_val("rst_xstate", {31'd0, xmon_xstate}, 32'd0);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // LR then SC
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_1234, 32'd0);
    idle(32'h8000_123C);
    idle(32'h8000_123C);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_123C, 32'd0);
    chk_val("lrsc_xstate", {31'd0, s_x}, 32'd1);
    idle(32'h8000_123C);
    chk_val("sc_clear_vld", {31'd0, s_v}, 32'd0);
    chk_val("sc_clear_x", {31'd0, s_x}, 32'd0);

    // Granule mismatch
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_1230, 32'd0);
    idle(32'h8000_1240);
    chk_val("mismatch_x", {31'd0, s_x}, 32'd0);
    chk_val("mismatch_vld", {31'd0, s_v}, 32'd1);

    // Snoop kill and snoop miss
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_2000, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_2000, 32'h8000_200C);
    chk_val("snp_n_x", {31'd0, s_x}, 32'd1);
    idle(32'h8000_2000);
    chk_val("snp_mask_x", {31'd0, s_x}, 32'd0);
    idle(32'h8000_2000);
    chk_val("snp_kill_vld", {31'd0, s_v}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_2000, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_2000, 32'h8000_2010);
    idle(32'h8000_2000);
    chk_val("snp_miss_x", {31'd0, s_x}, 32'd1);
    idle(32'h8000_2000);
    chk_val("snp_miss_vld", {31'd0, s_v}, 32'd1);

    // Snoop / LR race
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h8000_3000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_3004, 32'd0);
    idle(32'h8000_3004);
    chk_val("race_vld", {31'd0, s_v}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h8000_4000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_3004, 32'd0);
    idle(32'h8000_3004);
    chk_val("norace_vld", {31'd0, s_v}, 32'd1);
    chk_val("norace_addr", {4'd0, s_a}, 32'h0800_0300);

    // Same-cycle LR and clear
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_5000, 32'd0);
    idle(32'h8000_5000);
    chk_val("prio_clr_vld", {31'd0, s_v}, 32'd0);

    // Asynchronous reset mid-reservation
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_6000, 32'd0);
    lr_vld = 1'b0; sc_vld = 1'b0; xmon_clr = 1'b0; snp_vld = 1'b0; core_paddr = 32'h8000_6000;
    #1;
    chk_val("pre_rst_vld", {31'd0, resv_vld}, 32'd1);
    rstn = 1'b0;
    #1;
    chk_val("async_rst_vld", {31'd0, resv_vld}, 32'd0);
    chk_val("async_rst_x", {31'd0, xmon_xstate}, 32'd0);
    model_reset();
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    cyc++;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_6000, 32'd0);
    chk_val("post_rst_sc_x", {31'd0, s_x}, 32'd0);

    // Randomized traffic over four neighbouring granules
    for (int i = 0; i < 600; i++) begin
      pa = 32'h8000_0000 + 32'($urandom_range(0, 63));
      sa = 32'h8000_0000 + 32'($urandom_range(0, 63));
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0), pa, sa);
    end

    // Reservation lifetime with no other events
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_7000, 32'd0);
    for (int k = 1; k <= 1000; k++) begin
      idle(32'h8000_7000);
      if (k == 256) chk_val("life_256", {31'd0, s_v}, 32'd1);
`ifdef L1C_XMON_TIMEOUT_EN
      if (k == 257) chk_val("life_257", {31'd0, s_v}, 32'd0);
      if (k == 1000) chk_val("life_1000", {31'd0, s_v}, 32'd0);
`else
      if (k == 257) chk_val("life_257", {31'd0, s_v}, 32'd1);
      if (k == 1000) chk_val("life_1000", {31'd0, s_v}, 32'd1);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
